dcache_snoop_responder: RTL and testbench
=========================================

Name: dcache_snoop_responder

Overview:
- Per-core, cache-side agent for the MSI snoop protocol run by the bus coherence controller.
- Reacts to snoop requests (ccwait with ccsnoopaddr) by looking up the dcache tag/state arrays.
- On an M hit it asserts cctrans and supplies the two-word block through dstore/daddr, then demotes the line M->S.
- On ccinv it invalidates the matching line. It sits beside the dcache FSM, shares its array ports, and stalls it through snp_busy.

Parameters:
- SETS, 8, dcache sets; IDXW = log2(SETS).
- WAYS, 2, associativity; WAYW = log2(WAYS).
- TAGW, 32-3-IDXW, tag width.
- Address split: [1:0] byte offset, [2] word-in-block, [IDXW+2:3] index, [31:IDXW+3] tag.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset
- ccwait  in  1  snoop request from the coherence controller
- ccinv  in  1  one-cycle invalidate pulse
- ccsnoopaddr  in  32  snooped word address
- dwait  in  1  controller word-accept (low = accepted)
- snp_idx  out  IDXW  array read index
- way_tag  in  WAYS*TAGW  tags at snp_idx
- way_state  in  WAYS*2  line state at snp_idx: 00 I, 01 S, 10 M
- way_data  in  WAYS*64  block data at snp_idx; word0 in [31:0]
- upd_en  out  1  state write strobe
- upd_way  out  WAYW  way to write
- upd_state  out  2  state value to write
- snp_cctrans  out  1  ORed externally into the cache's cctrans
- snp_drive  out  1  muxes snp_daddr/snp_dstore onto the cache's daddr/dstore
- snp_daddr  out  32  forwarded word address
- snp_dstore  out  32  forwarded word
- snp_busy  out  1  dcache FSM must hold and must not write the arrays

Behaviour:
- Reset: nRST asynchronous, active-low; clock CLK. Reset forces state IDLE, clears pend_inv and the latched address, and drives all outputs 0. Asserting reset mid-transfer aborts with no state write.
- snp_idx: taken from ccsnoopaddr in IDLE; from the latched address in all other states.
- Hit: tag match in a way whose state is not I. Lowest-index way wins on a (corrupt) double match.
- FSM states:
  - IDLE: on ccwait, latch the address and go to LOOKUP. Else, on ccinv, latch the address and go to INV. If both are asserted, ccwait wins and pend_inv is set. snp_busy = 0.
  - LOOKUP: register the hit way and state. M hit -> SEND0; otherwise -> DRAIN. snp_busy = 1.
  - SEND0:
    - Drives snp_cctrans=1, snp_drive=1, snp_daddr = {tag,idx,0,00}, snp_dstore = word0.
    - Word0 must be stable from the cycle after LOOKUP, because the controller samples cctrans on its 3rd ccwait cycle and latches dstore each cycle.
    - On dwait=0 -> SEND1.
  - SEND1: cctrans, drive and address +4; drives word1. On dwait=0 -> UPDATE.
  - UPDATE: upd_en=1, upd_state=S for the hit way; snp_cctrans=0. Next -> INV if pend_inv, else IDLE.
  - DRAIN (miss or S hit): no drive and no update; wait for ccwait=0 -> IDLE.
  - INV: on a hit, upd_en=1 and upd_state=I for the hit way; a miss is a no-op. Clear pend_inv -> IDLE.
- Outputs are Moore-decoded from state. snp_cctrans must be 0 in the cycle after word1 acceptance, so the controller never re-sees it in IDLE.
- ccinv arriving in any non-IDLE state sets pend_inv. It is serviced after UPDATE/DRAIN against the address latched at pend time (a separate inv address register).
- dwait held high indefinitely: remain in SEND0/SEND1 with outputs stable.
- Latency: M-hit snoop to state S = 2 + forward cycles + 1. Invalidate = 2 cycles from ccinv.
- snp_busy = 1 in every state except IDLE.

Optional Feature:
- Macro: SNOOP_STATS_EN.
- When defined, adds outputs:
  - stat_hits (32): counts LOOKUP hits.
  - stat_fwds (32): counts UPDATE entries.
  - stat_invs (32): counts INV hits.
- Counters saturate at all-ones and clear on reset.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Snoop miss: ccwait=1 for 3 cycles, addr 0x00000040, all ways I -> cctrans stays 0, no upd_en, return to IDLE after ccwait falls.
- M hit forward:
  - Stimulus: way1 M, tag match at 0x00000088, data {0xBEEF0001, 0xBEEF0000}; dwait low in the 4th and 6th cycles.
  - Required: cctrans=1 from cycle 2; daddr 0x88/dstore 0xBEEF0000, then 0x8C/0xBEEF0001; upd way1 -> S; cctrans=0 right after.
- S hit snoop: way0 S -> no cctrans, no update, DRAIN -> IDLE.
- Invalidate: ccinv pulse at 0x00000100, way0 S match -> upd_en, way0, I two cycles later; an unmatched address gives no upd_en.
- Invalidate during forward: ccinv while in SEND1 -> UPDATE(S) followed by INV(I) on the same line; snp_busy held throughout.
- Reset mid-SEND0: nRST low -> all outputs 0 immediately; IDLE after release; no state write.

Source files
------------

// File: rtl/dcache_snoop_responder.sv
// Cache-side MSI snoop agent: looks up the dcache arrays on a coherence snoop,
// forwards a Modified block over dstore/daddr and demotes it to S, and
// invalidates lines on ccinv. Stalls the dcache FSM through snp_busy.
// Optional counters (stat_hits/stat_fwds/stat_invs) under `SNOOP_STATS_EN.
module dcache_snoop_responder #(
   parameter  int unsigned SETS = 8,
   parameter  int unsigned WAYS = 2,
   localparam int unsigned IDXW = $clog2(SETS),
   localparam int unsigned WAYW = $clog2(WAYS),
   localparam int unsigned TAGW = 32 - 3 - IDXW
) (
   input  logic                 CLK,
   input  logic                 nRST,
   input  logic                 ccwait,
   input  logic                 ccinv,
   input  logic [31:0]          ccsnoopaddr,
   input  logic                 dwait,
   output logic [IDXW-1:0]      snp_idx,
   input  logic [WAYS*TAGW-1:0] way_tag,
   input  logic [WAYS*2-1:0]    way_state,
   input  logic [WAYS*64-1:0]   way_data,
   output logic                 upd_en,
   output logic [WAYW-1:0]      upd_way,
   output logic [1:0]           upd_state,
   output logic                 snp_cctrans,
   output logic                 snp_drive,
   output logic [31:0]          snp_daddr,
   output logic [31:0]          snp_dstore,
   output logic                 snp_busy
`ifdef SNOOP_STATS_EN
   ,
   output logic [31:0]          stat_hits,
   output logic [31:0]          stat_fwds,
   output logic [31:0]          stat_invs
`endif
);

   localparam int unsigned BLKW = 29;
   localparam logic [1:0] ST_I = 2'b00;
   localparam logic [1:0] ST_S = 2'b01;
   localparam logic [1:0] ST_M = 2'b10;

   typedef enum logic [2:0] {IDLE, LOOKUP, SEND0, SEND1, UPDATE, DRAIN, INV} state_t;

   state_t            state;
   logic [BLKW-1:0]   blk_q;
   logic [BLKW-1:0]   inv_blk_q;
   logic              pend_inv;
   logic [WAYW-1:0]   hit_way_q;

   logic [TAGW-1:0]   tag_a  [WAYS];
   logic [1:0]        st_a   [WAYS];
   logic [63:0]       data_a [WAYS];
   logic              hit_c;
   logic [WAYW-1:0]   hit_way_c;
   logic [1:0]        hit_st_c;
   logic              inv_pend_c;
   logic [BLKW-1:0]   inv_blk_c;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^ccsnoopaddr[2:0];

   // Array index: live snoop address while idle, latched block otherwise
   assign snp_idx = (state == IDLE) ? ccsnoopaddr[IDXW+2:3] : blk_q[IDXW-1:0];

   // Split the flat array buses into per-way views
   always_comb begin
      for (int w = 0; w < int'(WAYS); w++) begin
         tag_a[w]  = way_tag[w*TAGW +: TAGW];
         st_a[w]   = way_state[w*2 +: 2];
         data_a[w] = way_data[w*64 +: 64];
      end
   end

   // Tag match against the latched block; first (lowest) valid way wins
   always_comb begin
      hit_c     = 1'b0;
      hit_way_c = '0;
      hit_st_c  = ST_I;
      for (int w = 0; w < int'(WAYS); w++) begin
         if (!hit_c && st_a[w] != ST_I && tag_a[w] == blk_q[BLKW-1:IDXW]) begin
            hit_c     = 1'b1;
            hit_way_c = WAYW'(w);
            hit_st_c  = st_a[w];
         end
      end
   end

   // A ccinv arriving on the exit cycle of UPDATE/DRAIN is serviced directly
   assign inv_pend_c = pend_inv | ccinv;
   assign inv_blk_c  = ccinv ? ccsnoopaddr[31:3] : inv_blk_q;

   // State write strobes, aligned with snp_idx pointing at the line
   always_comb begin
      upd_en    = 1'b0;
      upd_way   = '0;
      upd_state = ST_I;
      if (state == UPDATE) begin
         upd_en    = 1'b1;
         upd_way   = hit_way_q;
         upd_state = ST_S;
      end else if (state == INV) begin
         upd_en    = hit_c;
         upd_way   = hit_way_c;
      end
   end

   // Snoop FSM with registered bus-side outputs
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state       <= IDLE;
         blk_q       <= '0;
         inv_blk_q   <= '0;
         pend_inv    <= 1'b0;
         hit_way_q   <= '0;
         snp_cctrans <= 1'b0;
         snp_drive   <= 1'b0;
         snp_daddr   <= '0;
         snp_dstore  <= '0;
         snp_busy    <= 1'b0;
      end else begin
         if (ccinv && state != IDLE) begin
            pend_inv  <= 1'b1;
            inv_blk_q <= ccsnoopaddr[31:3];
         end
         case (state)
            IDLE: begin
               if (ccwait) begin
                  blk_q    <= ccsnoopaddr[31:3];
                  state    <= LOOKUP;
                  snp_busy <= 1'b1;
                  if (ccinv) begin
                     pend_inv  <= 1'b1;
                     inv_blk_q <= ccsnoopaddr[31:3];
                  end
               end else if (ccinv) begin
                  blk_q    <= ccsnoopaddr[31:3];
                  state    <= INV;
                  snp_busy <= 1'b1;
               end
            end
            LOOKUP: begin
               hit_way_q <= hit_way_c;
               if (hit_c && hit_st_c == ST_M) begin
                  state       <= SEND0;
                  snp_cctrans <= 1'b1;
                  snp_drive   <= 1'b1;
                  snp_daddr   <= {blk_q, 3'b000};
                  snp_dstore  <= data_a[hit_way_c][31:0];
               end else begin
                  state <= DRAIN;
               end
            end
            SEND0: begin
               if (!dwait) begin
                  state      <= SEND1;
                  snp_daddr  <= {blk_q, 3'b100};
                  snp_dstore <= data_a[hit_way_q][63:32];
               end
            end
            SEND1: begin
               if (!dwait) begin
                  state       <= UPDATE;
                  snp_cctrans <= 1'b0;
                  snp_drive   <= 1'b0;
                  snp_daddr   <= '0;
                  snp_dstore  <= '0;
               end
            end
            UPDATE, DRAIN: begin
               if (state == UPDATE || !ccwait) begin
                  if (inv_pend_c) begin
                     blk_q <= inv_blk_c;
                     state <= INV;
                  end else begin
                     state    <= IDLE;
                     snp_busy <= 1'b0;
                  end
               end
            end
            INV: begin
               if (ccinv) begin
                  blk_q <= ccsnoopaddr[31:3];
               end else begin
                  pend_inv <= 1'b0;
                  state    <= IDLE;
                  snp_busy <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               snp_busy <= 1'b0;
            end
         endcase
      end
   end

`ifdef SNOOP_STATS_EN
   // Saturating event counters
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stat_hits <= '0;
         stat_fwds <= '0;
         stat_invs <= '0;
      end else begin
         if (state == LOOKUP && hit_c && stat_hits != '1) stat_hits <= stat_hits + 32'd1;
         if (state == UPDATE && stat_fwds != '1)          stat_fwds <= stat_fwds + 32'd1;
         if (state == INV && hit_c && stat_invs != '1)    stat_invs <= stat_invs + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dcache_snoop_responder.sv
// Bench for dcache_snoop_responder: array model, scoreboard of forwarded words
// and state writes, table-driven snoop/invalidate vectors plus timing sequences.
module tb_dcache_snoop_responder;

   localparam logic [1:0] SI = 2'b00;
   localparam logic [1:0] SS = 2'b01;
   localparam logic [1:0] SM = 2'b10;

   logic        CLK;
   logic        nRST;
   logic        ccwait;
   logic        ccinv;
   logic [31:0] ccsnoopaddr;
   logic        dwait;
   logic [2:0]  snp_idx;
   logic [51:0] way_tag;
   logic [3:0]  way_state;
   logic [127:0] way_data;
   logic        upd_en;
   logic        upd_way;
   logic [1:0]  upd_state;
   logic        snp_cctrans;
   logic        snp_drive;
   logic [31:0] snp_daddr;
   logic [31:0] snp_dstore;
   logic        snp_busy;
`ifdef SNOOP_STATS_EN
   logic [31:0] stat_hits;
   logic [31:0] stat_fwds;
   logic [31:0] stat_invs;
`endif

   dcache_snoop_responder dut (
      .CLK(CLK), .nRST(nRST), .ccwait(ccwait), .ccinv(ccinv),
      .ccsnoopaddr(ccsnoopaddr), .dwait(dwait), .snp_idx(snp_idx),
      .way_tag(way_tag), .way_state(way_state), .way_data(way_data),
      .upd_en(upd_en), .upd_way(upd_way), .upd_state(upd_state),
      .snp_cctrans(snp_cctrans), .snp_drive(snp_drive),
      .snp_daddr(snp_daddr), .snp_dstore(snp_dstore), .snp_busy(snp_busy)
`ifdef SNOOP_STATS_EN
      , .stat_hits(stat_hits), .stat_fwds(stat_fwds), .stat_invs(stat_invs)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Cache array model
   logic [25:0] mtag [8][2];
   logic [1:0]  mst  [8][2];
   logic        clr_en, pre_en;
   logic [2:0]  pre_idx;
   logic [1:0]  pre_s0, pre_s1;
   logic [25:0] pre_t0, pre_t1;

   function automatic logic [31:0] word(input int idx, input int w, input int k);
      return {8'hBE, 8'(idx), 8'(w), 8'(k)};
   endfunction

   always_comb begin
      for (int w = 0; w < 2; w++) begin
         way_tag[w*26 +: 26]  = mtag[snp_idx][w];
         way_state[w*2 +: 2]  = mst[snp_idx][w];
         way_data[w*64 +: 64] = {word(int'(snp_idx), w, 1), word(int'(snp_idx), w, 0)};
      end
   end

   always @(posedge CLK) begin
      if (clr_en) begin
         for (int s = 0; s < 8; s++)
            for (int w = 0; w < 2; w++) begin
               mst[s][w]  <= SI;
               mtag[s][w] <= '0;
            end
      end else if (pre_en) begin
         mst[pre_idx][0]  <= pre_s0;
         mst[pre_idx][1]  <= pre_s1;
         mtag[pre_idx][0] <= pre_t0;
         mtag[pre_idx][1] <= pre_t1;
      end else if (upd_en) begin
         mst[snp_idx][upd_way] <= upd_state;
      end
   end

   // Checking infrastructure
   int checks = 0;
   int failures = 0;
   logic [63:0] fwd_q [$];
   logic [2:0]  upd_q [$];
   logic        cctrans_seen;
   int          acc_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Monitor: pop expected forwards on word accept and expected state writes
   initial begin
      logic [63:0] ef;
      logic [2:0]  eu;
      forever begin
         @(negedge CLK);
         if (nRST) begin
            if (snp_cctrans) cctrans_seen = 1'b1;
            if (snp_drive && !dwait) begin
               acc_cnt++;
               if (fwd_q.size() == 0) begin
                  chk("fwd_unexpected", snp_daddr, 32'hFFFFFFFF);
               end else begin
                  ef = fwd_q.pop_front();
                  chk("fwd_addr", snp_daddr, ef[63:32]);
                  chk("fwd_data", snp_dstore, ef[31:0]);
                  chk("fwd_cctrans", 32'(snp_cctrans), 32'd1);
               end
            end
            if (upd_en) begin
               if (upd_q.size() == 0) begin
                  chk("upd_unexpected", {29'd0, upd_way, upd_state}, 32'hFFFFFFFF);
               end else begin
                  eu = upd_q.pop_front();
                  chk("upd_way_state", {29'd0, upd_way, upd_state}, {29'd0, eu});
               end
            end
         end
      end
   end

   task automatic preload(input logic [2:0] idx, input logic [1:0] s0, input logic [1:0] s1,
                          input logic [25:0] t0, input logic [25:0] t1);
      pre_idx = idx; pre_s0 = s0; pre_s1 = s1; pre_t0 = t0; pre_t1 = t1;
      pre_en = 1'b1;
      tick();
      pre_en = 1'b0;
   endtask

   typedef struct {
      logic [31:0] addr;
      logic        inv;
      logic [1:0]  st0, st1;
      logic        m0, m1;
      logic        fway;
      logic        exp_fwd;
      logic [1:0]  exp0, exp1;
   } vec_t;

   vec_t vecs [8];

   task automatic run_vec(input int n, input vec_t v);
      logic [2:0]  idx;
      logic [25:0] tg;
      bit          done;
      idx = v.addr[5:3];
      tg  = v.addr[31:6];
      preload(idx, v.st0, v.st1, v.m0 ? tg : tg ^ 26'h1, v.m1 ? tg : tg ^ 26'h1);
      if (v.exp_fwd) begin
         fwd_q.push_back({v.addr[31:3], 3'b000, word(int'(idx), int'(v.fway), 0)});
         fwd_q.push_back({v.addr[31:3], 3'b100, word(int'(idx), int'(v.fway), 1)});
      end
      if (v.exp0 != v.st0) upd_q.push_back({1'b0, v.exp0});
      if (v.exp1 != v.st1) upd_q.push_back({1'b1, v.exp1});
      cctrans_seen = 1'b0;
      acc_cnt = 0;
      ccsnoopaddr = v.addr;
      if (v.inv) ccinv = 1'b1;
      else       ccwait = 1'b1;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         tick();
         ccinv = 1'b0;
         dwait = ($urandom_range(0, 2) == 0);
         if (ccwait && (v.exp_fwd ? (acc_cnt >= 2) : (c >= 2))) ccwait = 1'b0;
         if (c >= 3 && !ccwait && !snp_busy) done = 1'b1;
      end
      ccwait = 1'b0;
      dwait  = 1'b1;
      chk($sformatf("v%0d_complete", n), 32'(done), 32'd1);
      chk($sformatf("v%0d_fwd_left", n), fwd_q.size(), 32'd0);
      chk($sformatf("v%0d_upd_left", n), upd_q.size(), 32'd0);
      chk($sformatf("v%0d_cctrans", n), 32'(cctrans_seen), 32'(v.exp_fwd));
      chk($sformatf("v%0d_way0", n), 32'(mst[idx][0]), 32'(v.exp0));
      chk($sformatf("v%0d_way1", n), 32'(mst[idx][1]), 32'(v.exp1));
      fwd_q.delete();
      upd_q.delete();
   endtask

   initial begin
      nRST = 1'b0; ccwait = 1'b0; ccinv = 1'b0; ccsnoopaddr = '0; dwait = 1'b1;
      clr_en = 1'b1; pre_en = 1'b0; pre_idx = '0;
      pre_s0 = SI; pre_s1 = SI; pre_t0 = '0; pre_t1 = '0;
      cctrans_seen = 1'b0; acc_cnt = 0;
      vecs[0] = '{addr:32'h040, inv:1'b0, st0:SI, st1:SI, m0:1'b1, m1:1'b1, fway:1'b0, exp_fwd:1'b0, exp0:SI, exp1:SI};
      vecs[1] = '{addr:32'h088, inv:1'b0, st0:SI, st1:SM, m0:1'b0, m1:1'b1, fway:1'b1, exp_fwd:1'b1, exp0:SI, exp1:SS};
      vecs[2] = '{addr:32'h0C8, inv:1'b0, st0:SS, st1:SM, m0:1'b1, m1:1'b0, fway:1'b0, exp_fwd:1'b0, exp0:SS, exp1:SM};
      vecs[3] = '{addr:32'h100, inv:1'b1, st0:SS, st1:SS, m0:1'b1, m1:1'b0, fway:1'b0, exp_fwd:1'b0, exp0:SI, exp1:SS};
      vecs[4] = '{addr:32'h140, inv:1'b1, st0:SS, st1:SM, m0:1'b0, m1:1'b0, fway:1'b0, exp_fwd:1'b0, exp0:SS, exp1:SM};
      vecs[5] = '{addr:32'h1F8, inv:1'b0, st0:SM, st1:SM, m0:1'b1, m1:1'b1, fway:1'b0, exp_fwd:1'b1, exp0:SS, exp1:SM};
      vecs[6] = '{addr:32'h2A0, inv:1'b1, st0:SM, st1:SM, m0:1'b0, m1:1'b1, fway:1'b0, exp_fwd:1'b0, exp0:SM, exp1:SI};
      vecs[7] = '{addr:32'h3C4, inv:1'b0, st0:SM, st1:SI, m0:1'b1, m1:1'b1, fway:1'b0, exp_fwd:1'b1, exp0:SS, exp1:SI};
      repeat (3) tick();
      clr_en = 1'b0;
      nRST = 1'b1;
      tick();

      // Reset state
      chk("rst_busy", 32'(snp_busy), 32'd0);
      chk("rst_cctrans", 32'(snp_cctrans), 32'd0);
      chk("rst_drive", 32'(snp_drive), 32'd0);
      chk("rst_daddr", snp_daddr, 32'd0);
      chk("rst_dstore", snp_dstore, 32'd0);
      chk("rst_upd_en", 32'(upd_en), 32'd0);

      // Table vectors
      for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

      // M-hit forward timing with dwait low throughout
      preload(3'd1, SI, SM, 26'd0, 26'd2);
      fwd_q.push_back({32'h88, word(1, 1, 0)});
      fwd_q.push_back({32'h8C, word(1, 1, 1)});
      upd_q.push_back({1'b1, SS});
      dwait = 1'b0; ccsnoopaddr = 32'h88; ccwait = 1'b1;
      tick();
      chk("a_lookup_cctrans", 32'(snp_cctrans), 32'd0);
      chk("a_lookup_busy", 32'(snp_busy), 32'd1);
      tick();
      chk("a_send0_cctrans", 32'(snp_cctrans), 32'd1);
      chk("a_send0_daddr", snp_daddr, 32'h88);
      chk("a_send0_dstore", snp_dstore, word(1, 1, 0));
      tick();
      chk("a_send1_daddr", snp_daddr, 32'h8C);
      chk("a_send1_dstore", snp_dstore, word(1, 1, 1));
      tick();
      chk("a_update_cctrans", 32'(snp_cctrans), 32'd0);
      chk("a_update_en", 32'(upd_en), 32'd1);
      chk("a_update_st", {31'd0, upd_way, upd_state} , {31'd0, 1'b1, SS});
      ccwait = 1'b0; dwait = 1'b1;
      tick();
      chk("a_idle_busy", 32'(snp_busy), 32'd0);
      chk("a_line_s", 32'(mst[1][1]), 32'(SS));

      // Invalidate latency, hit then miss
      preload(3'd0, SS, SI, 26'd4, 26'd4);
      upd_q.push_back({1'b0, SI});
      ccsnoopaddr = 32'h100; ccinv = 1'b1;
      tick();
      ccinv = 1'b0;
      chk("b_inv_en", 32'(upd_en), 32'd1);
      chk("b_inv_way", 32'(upd_way), 32'd0);
      chk("b_inv_state", 32'(upd_state), 32'(SI));
      chk("b_inv_busy", 32'(snp_busy), 32'd1);
      tick();
      chk("b_line_i", 32'(mst[0][0]), 32'(SI));
      chk("b_idle_busy", 32'(snp_busy), 32'd0);
      preload(3'd0, SS, SI, 26'd4, 26'd4);
      ccsnoopaddr = 32'h140; ccinv = 1'b1;
      tick();
      ccinv = 1'b0;
      chk("b_miss_en", 32'(upd_en), 32'd0);
      tick();
      chk("b_miss_line", 32'(mst[0][0]), 32'(SS));

      // Invalidate arriving during SEND1, with dwait stalls
      preload(3'd1, SM, SI, 26'd2, 26'd0);
      fwd_q.push_back({32'h88, word(1, 0, 0)});
      fwd_q.push_back({32'h8C, word(1, 0, 1)});
      upd_q.push_back({1'b0, SS});
      upd_q.push_back({1'b0, SI});
      dwait = 1'b0; ccsnoopaddr = 32'h88; ccwait = 1'b1;
      tick();
      tick();
      dwait = 1'b1;
      tick();
      chk("c_hold_cctrans", 32'(snp_cctrans), 32'd1);
      chk("c_hold_daddr", snp_daddr, 32'h88);
      chk("c_hold_dstore", snp_dstore, word(1, 0, 0));
      dwait = 1'b0;
      tick();
      dwait = 1'b1; ccinv = 1'b1;
      tick();
      ccinv = 1'b0; dwait = 1'b0;
      chk("c_send1_busy", 32'(snp_busy), 32'd1);
      chk("c_send1_daddr", snp_daddr, 32'h8C);
      tick();
      chk("c_update", {29'd0, upd_en, upd_state}, {29'd0, 1'b1, SS});
      chk("c_update_busy", 32'(snp_busy), 32'd1);
      ccwait = 1'b0; dwait = 1'b1;
      tick();
      chk("c_inv", {29'd0, upd_en, upd_state}, {29'd0, 1'b1, SI});
      chk("c_inv_busy", 32'(snp_busy), 32'd1);
      tick();
      chk("c_idle_busy", 32'(snp_busy), 32'd0);
      chk("c_line_i", 32'(mst[1][0]), 32'(SI));
      chk("c_queues", fwd_q.size() + upd_q.size(), 32'd0);
      fwd_q.delete();
      upd_q.delete();

      // Reset while forwarding word0
      preload(3'd1, SI, SM, 26'd0, 26'd2);
      dwait = 1'b1; ccsnoopaddr = 32'h88; ccwait = 1'b1;
      tick();
      tick();
      chk("d_send0_cctrans", 32'(snp_cctrans), 32'd1);
      #2;
      nRST = 1'b0; ccsnoopaddr = '0;
      #1;
      chk("d_rst_outs", {23'd0, snp_cctrans, snp_drive, snp_busy, upd_en, upd_way, upd_state, snp_idx[0]}, 32'd0);
      chk("d_rst_daddr", snp_daddr, 32'd0);
      chk("d_rst_dstore", snp_dstore, 32'd0);
      ccwait = 1'b0;
      tick();
      tick();
      nRST = 1'b1;
      tick();
      chk("d_idle_busy", 32'(snp_busy), 32'd0);
      chk("d_line_kept", 32'(mst[1][1]), 32'(SM));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
